// File: rtl/cf_tilt_scheduler_pkg.sv
// Shared types, Q-format widths and saturation helper for the tilt scheduler.
package cf_tilt_scheduler_pkg;

  localparam int unsigned SAMPLE_W      = 16;  // raw gyro / Q1.14 accel
  localparam int unsigned PHASE_W       = 16;  // Q2.13 radians
  localparam int unsigned ANGLE_W       = 16;  // Q8.7 degrees
  localparam int unsigned PRED_W        = 17;  // angle + gyro step headroom
  localparam int unsigned PROD_W        = 32;  // phase * rad2deg product
  localparam int unsigned ACC_W         = 34;  // Q15 blend accumulator
  localparam int unsigned Q15_ONE       = 32768;
  localparam int unsigned Q15_SHIFT     = 15;
  localparam int unsigned RAD2DEG_SHIFT = 14;
  localparam int          RAD2DEG_Q8    = 14668;  // 180/pi in Q8

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FUSE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] gyro_x;
    logic signed [SAMPLE_W-1:0] gyro_y;
    logic signed [SAMPLE_W-1:0] accel_x;
    logic signed [SAMPLE_W-1:0] accel_y;
    logic signed [SAMPLE_W-1:0] accel_z;
  } sample_t;

  // Clamp a wide signed value into the 16-bit angle range.
  function automatic logic signed [ANGLE_W-1:0] sat_angle(input logic signed [ACC_W-1:0] v);
    logic signed [ANGLE_W-1:0] r;
    if (v > SAT_MAX) begin
      r = {1'b0, {(ANGLE_W-1){1'b1}}};
    end else if (v < SAT_MIN) begin
      r = {1'b1, {(ANGLE_W-1){1'b0}}};
    end else begin
      r = ANGLE_W'(v);
    end
    return r;
  endfunction

endpackage

// File: rtl/cf_tilt_scheduler_if.sv
// Sample, arctan-core and angle-output bundle of the tilt scheduler.
interface cf_tilt_scheduler_if;
  import cf_tilt_scheduler_pkg::*;

  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] gyro_x;
  logic signed [SAMPLE_W-1:0] gyro_y;
  logic signed [SAMPLE_W-1:0] accel_x;
  logic signed [SAMPLE_W-1:0] accel_y;
  logic signed [SAMPLE_W-1:0] accel_z;
  logic signed [SAMPLE_W-1:0] atan_x;
  logic signed [SAMPLE_W-1:0] atan_y;
  logic signed [PHASE_W-1:0]  atan_phase;
  logic signed [ANGLE_W-1:0]  roll;
  logic signed [ANGLE_W-1:0]  pitch;
  logic                       busy;
  logic                       done;
  logic                       overrun;
  logic                       clear_overrun;

  modport master (
    output sample_valid, gyro_x, gyro_y, accel_x, accel_y, accel_z,
    output atan_phase, clear_overrun,
    input  atan_x, atan_y, roll, pitch, busy, done, overrun
  );

  modport slave (
    input  sample_valid, gyro_x, gyro_y, accel_x, accel_y, accel_z,
    input  atan_phase, clear_overrun,
    output atan_x, atan_y, roll, pitch, busy, done, overrun
  );

endinterface

// File: rtl/cf_fuse_unit.sv
// Combinational gyro/accelerometer fusion for one axis.
module cf_fuse_unit
  import cf_tilt_scheduler_pkg::*;
#(
  parameter int unsigned GYRO_SHIFT = 6,
  parameter int unsigned ALPHA_Q15  = 32256
) (
  input  logic signed [PHASE_W-1:0]  phase,
  input  logic signed [SAMPLE_W-1:0] gyro,
  input  logic signed [ANGLE_W-1:0]  angle,
  input  logic                       primed,
  output logic signed [ANGLE_W-1:0]  angle_next_c
);

  localparam logic signed [PROD_W-1:0] K_RAD2DEG = PROD_W'(RAD2DEG_Q8);
  localparam logic signed [ACC_W-1:0]  W_GYRO    = ACC_W'(ALPHA_Q15);
  localparam logic signed [ACC_W-1:0]  W_ACCEL   = ACC_W'(Q15_ONE - ALPHA_Q15);
  localparam logic signed [ACC_W-1:0]  ROUND_Q15 = ACC_W'(Q15_ONE / 2);

  logic signed [PROD_W-1:0]   prod;
  logic signed [PROD_W-1:0]   acc_deg;
  logic signed [SAMPLE_W-1:0] step;
  logic signed [PRED_W-1:0]   pred;
  logic signed [ACC_W-1:0]    mix;
  logic signed [ACC_W-1:0]    mix_q15;

  // acc_deg, gyro prediction, rounded Q15 blend; unprimed axes take acc_deg directly.
  always_comb begin
    prod         = PROD_W'(phase) * K_RAD2DEG;
    acc_deg      = prod >>> RAD2DEG_SHIFT;
    step         = gyro >>> GYRO_SHIFT;
    pred         = PRED_W'(angle) + PRED_W'(step);
    mix          = W_GYRO * ACC_W'(pred) + W_ACCEL * ACC_W'(acc_deg) + ROUND_Q15;
    mix_q15      = mix >>> Q15_SHIFT;
    angle_next_c = primed ? sat_angle(mix_q15) : sat_angle(ACC_W'(acc_deg));
  end

endmodule

// File: rtl/cf_tilt_scheduler.sv
// Complementary-filter sequencer: shares one arctan core between roll and pitch.
module cf_tilt_scheduler
  import cf_tilt_scheduler_pkg::*;
#(
  parameter int unsigned ATAN_LAT   = 16,
  parameter int unsigned GYRO_SHIFT = 6,
  parameter int unsigned ALPHA_Q15  = 32256
) (
  input  logic                clk,
  input  logic                RST,
  cf_tilt_scheduler_if.slave  bus
);

  localparam int unsigned       CNT_W    = (ATAN_LAT > 1) ? $clog2(ATAN_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ATAN_LAT - 1);

  state_e                     state, state_next;
  logic                       ax, ax_next;
  logic [CNT_W-1:0]           cnt, cnt_next;
  logic                       accept_c, capture_c, fuse_c, load_ops_c, overrun_next_c;
  sample_t                    smp, bus_sample_c, op_src_c;
  logic signed [PHASE_W-1:0]  phase_q;
  logic signed [SAMPLE_W-1:0] atan_x_q, atan_y_q, atan_x_next_c, atan_y_next_c;
  logic signed [ANGLE_W-1:0]  roll_q, pitch_q, angle_new_c;
  logic signed [SAMPLE_W-1:0] fuse_gyro_c;
  logic signed [ANGLE_W-1:0]  fuse_angle_c;
  logic                       fuse_primed_c;
  logic [1:0]                 primed_q;
  logic                       busy_q, done_q, overrun_q;

  // FSM state, axis index and arctan wait counter.
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= ST_IDLE;
      ax    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      ax    <= ax_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    state_next = state;
    ax_next    = ax;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    capture_c  = 1'b0;
    fuse_c     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.sample_valid) begin
          accept_c   = 1'b1;
          ax_next    = 1'b0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_next   = CNT_LOAD;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          capture_c  = 1'b1;
          state_next = ST_FUSE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      ST_FUSE: begin
        fuse_c = 1'b1;
        if (!ax) begin
          ax_next    = 1'b1;
          state_next = ST_ISSUE;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand source: live bus on acceptance (roll), latched sample afterwards (pitch).
  always_comb begin
    bus_sample_c   = '{gyro_x:  bus.gyro_x,  gyro_y:  bus.gyro_y,
                       accel_x: bus.accel_x, accel_y: bus.accel_y, accel_z: bus.accel_z};
    op_src_c       = (state == ST_IDLE) ? bus_sample_c : smp;
    load_ops_c     = accept_c || (fuse_c && !ax);
    atan_x_next_c  = ax_next ? op_src_c.accel_x : op_src_c.accel_y;
    atan_y_next_c  = op_src_c.accel_z;
    overrun_next_c = overrun_q;
    if (bus.clear_overrun) overrun_next_c = 1'b0;
    if (bus.sample_valid && (state != ST_IDLE)) overrun_next_c = 1'b1;
  end

  // Fusion operand mux by axis.
  always_comb begin
    fuse_gyro_c   = ax ? smp.gyro_y : smp.gyro_x;
    fuse_angle_c  = ax ? pitch_q : roll_q;
    fuse_primed_c = primed_q[ax];
  end

  cf_fuse_unit #(
    .GYRO_SHIFT (GYRO_SHIFT),
    .ALPHA_Q15  (ALPHA_Q15)
  ) u_fuse (
    .phase        (phase_q),
    .gyro         (fuse_gyro_c),
    .angle        (fuse_angle_c),
    .primed       (fuse_primed_c),
    .angle_next_c (angle_new_c)
  );

  // Sample latch, core operands, phase capture, filter state and status outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      smp       <= '0;
      atan_x_q  <= '0;
      atan_y_q  <= '0;
      phase_q   <= '0;
      roll_q    <= '0;
      pitch_q   <= '0;
      primed_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept_c) smp <= bus_sample_c;
      if (load_ops_c) begin
        atan_x_q <= atan_x_next_c;
        atan_y_q <= atan_y_next_c;
      end
      if (capture_c) phase_q <= bus.atan_phase;
      if (fuse_c) begin
        if (ax) pitch_q <= angle_new_c;
        else    roll_q  <= angle_new_c;
        primed_q[ax] <= 1'b1;
      end
      busy_q    <= (state_next != ST_IDLE);
      done_q    <= (state_next == ST_DONE);
      overrun_q <= overrun_next_c;
    end
  end

  assign bus.atan_x  = atan_x_q;
  assign bus.atan_y  = atan_y_q;
  assign bus.roll    = roll_q;
  assign bus.pitch   = pitch_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_cf_tilt_scheduler.sv
// Scoreboard bench: default-latency instance plus a minimum-latency instance.
module tb_cf_tilt_scheduler;
  import cf_tilt_scheduler_pkg::*;

  localparam int unsigned LAT0  = 16;
  localparam int unsigned LAT1  = 1;
  localparam int unsigned GSH   = 6;
  localparam int unsigned ALPHA = 32256;
  localparam longint      W_G   = 32256;
  localparam longint      W_A   = 512;

  localparam int SEL_ROLL = 0, SEL_PITCH = 1, SEL_BUSY = 2, SEL_DONE = 3;
  localparam int SEL_OVR = 4, SEL_AX = 5, SEL_AY = 6;

  typedef struct {
    int roll;
    int pitch;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   m_angle [2][2];
  bit   m_primed[2][2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cf_tilt_scheduler_if bus0();
  cf_tilt_scheduler_if bus1();

  cf_tilt_scheduler #(.ATAN_LAT(LAT0), .GYRO_SHIFT(GSH), .ALPHA_Q15(ALPHA))
    u_dut0 (.clk(clk), .RST(rst0), .bus(bus0.slave));
  cf_tilt_scheduler #(.ATAN_LAT(LAT1), .GYRO_SHIFT(GSH), .ALPHA_Q15(ALPHA))
    u_dut1 (.clk(clk), .RST(rst1), .bus(bus1.slave));

  // Behavioural arctan core: round(atan2(x, y) * 2^13), x as numerator.
  function automatic int core_phase(input int num, input int den);
    real r;
    r = $atan2(real'(num), real'(den)) * 8192.0;
    if (r >= 0.0) return $rtoi(r + 0.5);
    return -$rtoi(-r + 0.5);
  endfunction

  // Arctan cores with ATAN_LAT-cycle pipelines.
  logic signed [15:0] pipe0 [LAT0];
  logic signed [15:0] pipe1 [LAT1];
  always @(posedge clk) begin
    pipe0[0] <= 16'(core_phase(int'(bus0.atan_x), int'(bus0.atan_y)));
    for (int i = 1; i < LAT0; i++) pipe0[i] <= pipe0[i-1];
    pipe1[0] <= 16'(core_phase(int'(bus1.atan_x), int'(bus1.atan_y)));
    for (int i = 1; i < LAT1; i++) pipe1[i] <= pipe1[i-1];
  end
  assign bus0.atan_phase = pipe0[LAT0-1];
  assign bus1.atan_phase = pipe1[LAT1-1];

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference complementary filter for one axis update.
  function automatic int model_axis(input int angle, input bit primed, input int phase, input int gyro);
    longint acc_deg, pred, mix;
    acc_deg = (longint'(phase) * 14668) >>> 14;
    if (!primed) return sat16(acc_deg);
    pred = longint'(angle) + longint'(gyro >>> GSH);
    mix  = (W_G * pred + W_A * acc_deg + 16384) >>> 15;
    return sat16(mix);
  endfunction

  function automatic int rd(input int inst, input int sel);
    if (inst == 0) begin
      case (sel)
        SEL_ROLL:  return int'(bus0.roll);
        SEL_PITCH: return int'(bus0.pitch);
        SEL_BUSY:  return int'(bus0.busy);
        SEL_DONE:  return int'(bus0.done);
        SEL_OVR:   return int'(bus0.overrun);
        SEL_AX:    return int'(bus0.atan_x);
        default:   return int'(bus0.atan_y);
      endcase
    end
    case (sel)
      SEL_ROLL:  return int'(bus1.roll);
      SEL_PITCH: return int'(bus1.pitch);
      SEL_BUSY:  return int'(bus1.busy);
      SEL_DONE:  return int'(bus1.done);
      SEL_OVR:   return int'(bus1.overrun);
      SEL_AX:    return int'(bus1.atan_x);
      default:   return int'(bus1.atan_y);
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input int inst, input int gx, input int gy, input int ax, input int ay, input int az);
    if (inst == 0) begin
      bus0.sample_valid = 1'b1;
      bus0.gyro_x = 16'(gx); bus0.gyro_y = 16'(gy);
      bus0.accel_x = 16'(ax); bus0.accel_y = 16'(ay); bus0.accel_z = 16'(az);
    end else begin
      bus1.sample_valid = 1'b1;
      bus1.gyro_x = 16'(gx); bus1.gyro_y = 16'(gy);
      bus1.accel_x = 16'(ax); bus1.accel_y = 16'(ay); bus1.accel_z = 16'(az);
    end
  endtask

  task automatic set_ctl(input int inst, input bit valid, input bit clr);
    if (inst == 0) begin bus0.sample_valid = valid; bus0.clear_overrun = clr; end
    else           begin bus1.sample_valid = valid; bus1.clear_overrun = clr; end
  endtask

  task automatic set_rst(input int inst, input logic v);
    if (inst == 0) rst0 = v; else rst1 = v;
  endtask

  task automatic model_reset(input int inst);
    m_angle[inst][0] = 0; m_angle[inst][1] = 0;
    m_primed[inst][0] = 1'b0; m_primed[inst][1] = 1'b0;
  endtask

  function automatic int rnd_accel();
    return int'($urandom_range(32768)) - 16384;
  endfunction

  function automatic int rnd_gyro();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  task automatic check_reset_outputs(input int inst);
    check("rst_roll",  rd(inst, SEL_ROLL),  0);
    check("rst_pitch", rd(inst, SEL_PITCH), 0);
    check("rst_busy",  rd(inst, SEL_BUSY),  0);
    check("rst_done",  rd(inst, SEL_DONE),  0);
    check("rst_ovr",   rd(inst, SEL_OVR),   0);
    check("rst_atanx", rd(inst, SEL_AX),    0);
    check("rst_atany", rd(inst, SEL_AY),    0);
  endtask

  // One sample through the scheduler; entered and left on a negedge at the earliest accept slot.
  task automatic run(input int inst, input int gx, input int gy, input int ax, input int ay,
                     input int az, input int drop_at, input bit clr_with_drop, input int rst_at);
    int   lat;
    int   old_r, old_p;
    exp_t e;
    lat   = (inst == 0) ? int'(LAT0) : int'(LAT1);
    old_r = m_angle[inst][0];
    old_p = m_angle[inst][1];
    e.roll     = model_axis(old_r, m_primed[inst][0], core_phase(ay, az), gx);
    e.pitch    = model_axis(old_p, m_primed[inst][1], core_phase(ax, az), gy);
    e.done_cyc = cyc + 2 * lat + 5;
    m_angle[inst][0] = e.roll;  m_primed[inst][0] = 1'b1;
    m_angle[inst][1] = e.pitch; m_primed[inst][1] = 1'b1;
    if (inst == 0) q0.push_back(e); else q1.push_back(e);
    drive(inst, gx, gy, ax, ay, az);
    for (int k = 1; k <= 2 * lat + 6; k++) begin
      @(negedge clk);
      set_ctl(inst, 1'b0, 1'b0);
      if (k == drop_at) begin
        drive(inst, rnd_gyro(), rnd_gyro(), rnd_accel(), rnd_accel(), rnd_accel());
        if (clr_with_drop) set_ctl(inst, 1'b1, 1'b1);
      end
      if (drop_at != 0 && k == drop_at + 1) check("overrun_on_drop", rd(inst, SEL_OVR), 1);
      if (rst_at != 0 && k == rst_at) set_rst(inst, 1'b1);
      if (rst_at != 0 && k == rst_at + 1) begin
        check_reset_outputs(inst);
        set_rst(inst, 1'b0);
        if (inst == 0) e = q0.pop_back(); else e = q1.pop_back();
        model_reset(inst);
      end
      if (rst_at == 0) begin
        if (k == 1)           check("busy_after_accept", rd(inst, SEL_BUSY), 1);
        if (k == lat + 2)     check("roll_before_fuse",  rd(inst, SEL_ROLL), old_r);
        if (k == lat + 3)     check("roll_after_fuse",   rd(inst, SEL_ROLL), e.roll);
        if (k == 2 * lat + 4) check("pitch_before_fuse", rd(inst, SEL_PITCH), old_p);
        if (k == 2 * lat + 5) check("pitch_after_fuse",  rd(inst, SEL_PITCH), e.pitch);
        if (k == 2 * lat + 6) check("busy_after_done",   rd(inst, SEL_BUSY), 0);
      end
    end
  endtask

  // Monitor: pops expected results whenever either instance pulses done.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.done === 1'b1) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL done0_unexpected: done seen at cycle %0d, required none", cyc);
      end else begin
        e = q0.pop_front();
        if (int'(bus0.roll) != e.roll || int'(bus0.pitch) != e.pitch || cyc != e.done_cyc) begin
          n_err++;
          $display("FAIL done0_result: roll %0d pitch %0d cycle %0d, required roll %0d pitch %0d cycle %0d",
                   bus0.roll, bus0.pitch, cyc, e.roll, e.pitch, e.done_cyc);
        end
      end
    end
    if (bus1.done === 1'b1) begin
      n_vec++;
      if (q1.size() == 0) begin
        n_err++;
        $display("FAIL done1_unexpected: done seen at cycle %0d, required none", cyc);
      end else begin
        e = q1.pop_front();
        if (int'(bus1.roll) != e.roll || int'(bus1.pitch) != e.pitch || cyc != e.done_cyc) begin
          n_err++;
          $display("FAIL done1_result: roll %0d pitch %0d cycle %0d, required roll %0d pitch %0d cycle %0d",
                   bus1.roll, bus1.pitch, cyc, e.roll, e.pitch, e.done_cyc);
        end
      end
    end
  end

  initial begin
    int prev;
    rst0 = 1'b1;
    rst1 = 1'b1;
    set_ctl(0, 1'b0, 1'b0);
    set_ctl(1, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    set_ctl(0, 1'b0, 1'b0);
    set_ctl(1, 1'b0, 1'b0);
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst0 = 1'b0;
    rst1 = 1'b0;
    @(negedge clk);

    // Level priming, then a pure gyro step of 10 LSB.
    run(0, 0, 0, 0, 0, 16384, 0, 1'b0, 0);
    run(0, 640, 0, 0, 0, 16384, 0, 1'b0, 0);
    check("roll_gyro_step", rd(0, SEL_ROLL), 10);

    // 45 degree priming straight from acc_deg.
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    model_reset(0);
    @(negedge clk);
    run(0, 0, 0, 0, 8192, 8192, 0, 1'b0, 0);
    check("roll_45_prime", rd(0, SEL_ROLL), 5760);

    // Overrun: drop mid-sequence, drop with simultaneous clear, clear alone, drop in DONE.
    run(0, rnd_gyro(), rnd_gyro(), rnd_accel(), rnd_accel(), rnd_accel(), 10, 1'b0, 0);
    check("overrun_sticky", rd(0, SEL_OVR), 1);
    run(0, rnd_gyro(), rnd_gyro(), rnd_accel(), rnd_accel(), rnd_accel(), 5, 1'b1, 0);
    check("overrun_set_wins", rd(0, SEL_OVR), 1);
    set_ctl(0, 1'b0, 1'b1);
    @(negedge clk);
    set_ctl(0, 1'b0, 1'b0);
    check("overrun_cleared", rd(0, SEL_OVR), 0);
    run(0, rnd_gyro(), rnd_gyro(), rnd_accel(), rnd_accel(), rnd_accel(), 2 * LAT0 + 5, 1'b0, 0);
    set_ctl(0, 1'b0, 1'b1);
    @(negedge clk);
    set_ctl(0, 1'b0, 1'b0);

    // Randomized samples.
    repeat (20) run(0, rnd_gyro(), rnd_gyro(), rnd_accel(), rnd_accel(), rnd_accel(), 0, 1'b0, 0);

    // Reset mid-sequence, then re-prime.
    run(0, rnd_gyro(), rnd_gyro(), rnd_accel(), rnd_accel(), rnd_accel(), 0, 1'b0, 20);
    repeat (4) @(negedge clk);
    run(0, rnd_gyro(), rnd_gyro(), rnd_accel(), rnd_accel(), rnd_accel(), 0, 1'b0, 0);

    // Saturation: 45 degree phase with full-scale gyro drives roll into the clamp.
    for (int s = 0; s < 150; s++) begin
      prev = rd(0, SEL_ROLL);
      run(0, 32767, rnd_gyro(), rnd_accel(), 8192, 8192, 0, 1'b0, 0);
      if (s % 10 == 9) check("roll_monotonic", int'(rd(0, SEL_ROLL) >= prev), 1);
    end
    check("roll_clamped", rd(0, SEL_ROLL), 32767);

    // Minimum latency: back-to-back samples at the earliest accept slot.
    repeat (8) run(1, rnd_gyro(), rnd_gyro(), rnd_accel(), rnd_accel(), rnd_accel(), 0, 1'b0, 0);
    check("minlat_no_overrun", rd(1, SEL_OVR), 0);

    repeat (10) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
